// File: rtl/layer_out_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | layer_out_serializer: buffers whole pixel vectors and replays them one     |
// | channel word per valid/ready beat, tagged with channel/column/row marks.   |
// | Optional: SERIALIZER_CHECKSUM_EN adds a per-frame modulo word sum.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module layer_out_serializer #(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNEL    = 128,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W  = (CHANNEL    > 1) ? $clog2(CHANNEL)    : 1,
  localparam int COL_W = (IMG_WIDHT  > 1) ? $clog2(IMG_WIDHT)  : 1,
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDHT*CHANNEL-1:0] Data_In,
  input  logic                          Valid_In,
  output logic [DATA_WIDHT-1:0]         Word_Out,
  output logic                          Word_Valid,
  input  logic                          Word_Ready,
  output logic [CH_W-1:0]               Ch_Idx,
  output logic [COL_W-1:0]              Col_Idx,
  output logic [ROW_W-1:0]              Row_Idx,
  output logic                          Last_Pixel,
  output logic                          Last_Frame,
  output logic                          Overflow
`ifdef SERIALIZER_CHECKSUM_EN
  ,
  output logic [DATA_WIDHT-1:0]         Frame_Sum,
  output logic                          Frame_Sum_Valid
`endif
);

  localparam int VEC_W = DATA_WIDHT * CHANNEL;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDHT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam bit               ONE_CH   = (CHANNEL == 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [VEC_W-1:0]      fifo_mem [FIFO_DEPTH];
  logic [VEC_W-1:0]      head;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop;
  logic                  xfer, last_xfer;
  logic [DATA_WIDHT-1:0] hold [CHANNEL];
  logic [CH_W-1:0]       ch_inc;
  logic [COL_W-1:0]      col_nxt, load_col;
  logic [ROW_W-1:0]      row_nxt, load_row;

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_FULL);
  assign xfer       = Word_Valid & Word_Ready;
  assign last_xfer  = xfer & (Ch_Idx == CH_LAST);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push       = Valid_In & (~fifo_full | pop);

  assign ch_inc  = Ch_Idx + CH_W'(1);
  assign col_nxt = (Col_Idx == COL_LAST) ? '0 : Col_Idx + COL_W'(1);
  assign row_nxt = (Col_Idx != COL_LAST) ? Row_Idx :
                   (Row_Idx == ROW_LAST) ? '0 : Row_Idx + ROW_W'(1);
  // Coordinates of a pixel popped back-to-back are those after the advance.
  assign load_col = last_xfer ? col_nxt : Col_Idx;
  assign load_row = last_xfer ? row_nxt : Row_Idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (last_xfer) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (Valid_In && fifo_full && !pop) Overflow <= 1'b1;
    end
  end

  // Storage only; validity is tracked by the pointers and count above.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= Data_In;
    if (pop) begin
      for (int k = 0; k < CHANNEL; k++) hold[k] <= head[k*DATA_WIDHT +: DATA_WIDHT];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Word_Out   <= '0;
      Word_Valid <= 1'b0;
      Ch_Idx     <= '0;
      Col_Idx    <= '0;
      Row_Idx    <= '0;
      Last_Pixel <= 1'b0;
      Last_Frame <= 1'b0;
    end else begin
      if (last_xfer) begin
        Col_Idx <= col_nxt;
        Row_Idx <= row_nxt;
      end
      if (pop) begin
        Word_Valid <= 1'b1;
        Word_Out   <= head[DATA_WIDHT-1:0];
        Ch_Idx     <= '0;
        Last_Pixel <= ONE_CH;
        Last_Frame <= ONE_CH && (load_col == COL_LAST) && (load_row == ROW_LAST);
      end else if (last_xfer) begin
        Word_Valid <= 1'b0;
        Ch_Idx     <= '0;
        Last_Pixel <= 1'b0;
        Last_Frame <= 1'b0;
      end else if (xfer) begin
        Word_Out   <= hold[ch_inc];
        Ch_Idx     <= ch_inc;
        Last_Pixel <= (ch_inc == CH_LAST);
        Last_Frame <= (ch_inc == CH_LAST) && (Col_Idx == COL_LAST) && (Row_Idx == ROW_LAST);
      end
    end
  end

`ifdef SERIALIZER_CHECKSUM_EN
  logic first_word;
  assign first_word = (Ch_Idx == '0) && (Col_Idx == '0) && (Row_Idx == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Frame_Sum       <= '0;
      Frame_Sum_Valid <= 1'b0;
    end else begin
      Frame_Sum_Valid <= xfer & Last_Frame;
      if (xfer) Frame_Sum <= first_word ? Word_Out : Frame_Sum + Word_Out;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_out_serializer.sv
`default_nettype none
// Directed bench for layer_out_serializer: 4 channels, 2x2 image, 2-deep FIFO.
module tb_layer_out_serializer;

  localparam int DW = 32;
  localparam int CH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DW*CH-1:0] Data_In = '0;
  logic             Valid_In = 1'b0;
  logic             Word_Ready = 1'b0;
  logic [DW-1:0]    Word_Out;
  logic             Word_Valid;
  logic [1:0]       Ch_Idx;
  logic [0:0]       Col_Idx, Row_Idx;
  logic             Last_Pixel, Last_Frame, Overflow;
`ifdef SERIALIZER_CHECKSUM_EN
  logic [DW-1:0]    Frame_Sum;
  logic             Frame_Sum_Valid;
  int               fsv_n = 0;
  int               fsv_stamp = 0;
  int               lf_stamp = 0;
  logic [DW-1:0]    fsv_sum = '0;
`endif

  typedef struct {
    logic [DW-1:0] word;
    logic [5:0]    meta;
    int            stamp;
  } rec_t;

  rec_t got[$];
  rec_t mon_r;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   first_stamp, last_stamp;

  layer_out_serializer #(
    .DATA_WIDHT(DW), .CHANNEL(CH), .IMG_WIDHT(2), .IMG_HEIGHT(2), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .Data_In(Data_In), .Valid_In(Valid_In),
    .Word_Out(Word_Out), .Word_Valid(Word_Valid), .Word_Ready(Word_Ready),
    .Ch_Idx(Ch_Idx), .Col_Idx(Col_Idx), .Row_Idx(Row_Idx),
    .Last_Pixel(Last_Pixel), .Last_Frame(Last_Frame), .Overflow(Overflow)
`ifdef SERIALIZER_CHECKSUM_EN
    , .Frame_Sum(Frame_Sum), .Frame_Sum_Valid(Frame_Sum_Valid)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are captured mid-cycle, half a period before the edge that completes them.
  always @(negedge clk) begin
    if (rst && Word_Valid && Word_Ready) begin
      mon_r.word  = Word_Out;
      mon_r.meta  = {Ch_Idx, Col_Idx, Row_Idx, Last_Pixel, Last_Frame};
      mon_r.stamp = cyc;
      got.push_back(mon_r);
`ifdef SERIALIZER_CHECKSUM_EN
      if (Last_Frame) lf_stamp = cyc;
`endif
    end
`ifdef SERIALIZER_CHECKSUM_EN
    if (rst && Frame_Sum_Valid) begin
      fsv_n++;
      fsv_sum   = Frame_Sum;
      fsv_stamp = cyc;
    end
`endif
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*CH-1:0] pix(input logic [DW-1:0] base);
    logic [DW*CH-1:0] v;
    for (int k = 0; k < CH; k++) v[k*DW +: DW] = base + DW'(k);
    return v;
  endfunction

  task automatic send_pixel(input logic [DW*CH-1:0] vec);
    Data_In  = vec;
    Valid_In = 1'b1;
    step(1);
    Valid_In = 1'b0;
  endtask

  task automatic expect_pixel(input logic [DW-1:0] base, input bit col, input bit row, input bit lf);
    rec_t       r;
    logic [5:0] m;
    for (int k = 0; k < CH; k++) begin
      if (got.size() == 0) begin
        check($sformatf("missing word base=%0h ch%0d", base, k), 64'd0, 64'd1);
        return;
      end
      r = got.pop_front();
      m = {2'(k), col, row, (k == CH-1), lf && (k == CH-1)};
      check($sformatf("word base=%0h ch%0d", base, k), r.word, base + DW'(k));
      check($sformatf("meta base=%0h ch%0d", base, k), r.meta, m);
      last_stamp = r.stamp;
    end
  endtask

  initial begin
    logic [3:0] rp;
    logic [40:0] pre;
    bit stalled;

    // Reset state
    step(3);
    check("rst valid", Word_Valid, 0);
    check("rst overflow", Overflow, 0);
    check("rst word", Word_Out, 0);
    check("rst idx", {Ch_Idx, Col_Idx, Row_Idx, Last_Pixel, Last_Frame}, 0);
    rst = 1'b1;
    step(2);

    // Single pixel: latency and channel order
    Word_Ready = 1'b1;
    send_pixel(pix(32'hA));
    check("t2 latency", Word_Valid, 0);
    for (int k = 0; k < CH; k++) begin
      step(1);
      check($sformatf("t2 valid %0d", k), Word_Valid, 1);
      check($sformatf("t2 word %0d", k), Word_Out, 32'hA + k);
      check($sformatf("t2 last_pixel %0d", k), Last_Pixel, (k == CH-1));
    end
    step(1);
    check("t2 drained", Word_Valid, 0);
    check("t2 col advanced", Col_Idx, 1);
    got.delete();

    // Backpressure with ready pattern 1,0,0,1
    rp = 4'b1001;
    send_pixel(pix(32'h20));
    for (int c = 0; c < 16; c++) begin
      Word_Ready = rp[c % 4];
      pre     = {Word_Valid, Word_Out, Ch_Idx, Col_Idx, Row_Idx, Last_Pixel, Last_Frame};
      stalled = Word_Valid && !Word_Ready;
      step(1);
      if (stalled)
        check($sformatf("t3 stable c%0d", c),
              {Word_Valid, Word_Out, Ch_Idx, Col_Idx, Row_Idx, Last_Pixel, Last_Frame}, pre);
    end
    Word_Ready = 1'b1;
    step(2);
    expect_pixel(32'h20, 1'b1, 1'b0, 1'b0);
    check("t3 no extra words", got.size(), 0);

    // Reset mid-pixel with another pixel queued
    Word_Ready = 1'b0;
    send_pixel(pix(32'h30));
    send_pixel(pix(32'h40));
    step(1);
    Word_Ready = 1'b1;
    step(2);
    check("t1 mid-pixel ch", Ch_Idx, 2);
    check("t1 mid-pixel row", Row_Idx, 1);
    Word_Ready = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("t1 async valid", Word_Valid, 0);
    check("t1 async idx", {Ch_Idx, Col_Idx, Row_Idx, Last_Pixel, Last_Frame}, 0);
    check("t1 async overflow", Overflow, 0);
    step(1);
    rst = 1'b1;
    Word_Ready = 1'b1;
    step(4);
    check("t1 fifo flushed", Word_Valid, 0);
    got.delete();

    // Full frame back-to-back, then first pixel of the next frame
    for (int p = 0; p < 5; p++) begin
      send_pixel(pix(32'h100 + 32'(16*p)));
      step(3);
    end
    step(4);
    first_stamp = (got.size() > 0) ? got[0].stamp : -100;
    expect_pixel(32'h100, 1'b0, 1'b0, 1'b0);
    expect_pixel(32'h110, 1'b1, 1'b0, 1'b0);
    expect_pixel(32'h120, 1'b0, 1'b1, 1'b0);
    expect_pixel(32'h130, 1'b1, 1'b1, 1'b1);
    expect_pixel(32'h140, 1'b0, 1'b0, 1'b0);
    check("t4 no bubble span", 64'(last_stamp - first_stamp), 19);
    check("t4 no extra words", got.size(), 0);

    // Overflow: fourth vector dropped while stalled
    check("t5 overflow before", Overflow, 0);
    Word_Ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      Data_In  = pix(32'h200 + 32'(16*p));
      Valid_In = 1'b1;
      step(1);
    end
    Valid_In = 1'b0;
    step(1);
    check("t5 overflow set", Overflow, 1);
    check("t5 stalled head", Word_Out, 32'h200);
    Word_Ready = 1'b1;
    step(16);
    expect_pixel(32'h200, 1'b1, 1'b0, 1'b0);
    expect_pixel(32'h210, 1'b0, 1'b1, 1'b0);
    expect_pixel(32'h220, 1'b1, 1'b1, 1'b1);
    check("t5 dropped vector absent", got.size(), 0);
    check("t5 overflow sticky", Overflow, 1);

    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    check("t5 overflow cleared by reset", Overflow, 0);

`ifdef SERIALIZER_CHECKSUM_EN
    // Checksum: words 1..16, then all-ones frame wrapping
    fsv_n = 0;
    for (int p = 0; p < 4; p++) begin
      send_pixel(pix(32'(4*p + 1)));
      step(3);
    end
    step(6);
    check("t6 sum 1..16", fsv_sum, 136);
    check("t6 pulse count", fsv_n, 1);
    check("t6 pulse timing", 64'(fsv_stamp - lf_stamp), 1);
    check("t6 sum held", Frame_Sum, 136);
    fsv_n = 0;
    for (int p = 0; p < 4; p++) begin
      send_pixel('1);
      step(3);
    end
    step(6);
    check("t6 sum wrap", fsv_sum, 32'hFFFF_FFF0);
    check("t6 wrap pulse count", fsv_n, 1);
    got.delete();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
